// File: rtl/pipe_ctrl_if.sv
// Hazard/handshake bundle between the pipeline datapath and pipe_ctrl.
// master = datapath side (drives hazard info), slave = controller side.
interface pipe_ctrl_if;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        idex_memR;
  logic [4:0]  idex_rt;
  logic        exmem_pcSel;
  logic        exmem_memR;
  logic        exmem_memW;
  logic        mem_ready;

  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        memwb_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        timeout;
  logic [15:0] stall_cnt;

  modport master (
    output ifid_rs, ifid_rt, idex_memR, idex_rt,
           exmem_pcSel, exmem_memR, exmem_memW, mem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           timeout, stall_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_memR, idex_rt,
           exmem_pcSel, exmem_memR, exmem_memW, mem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, branch flushes and
// data-memory wait states. Memory-wait support is built only with PIPE_CTRL_MEM_WAIT_EN.
module pipe_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    M_RESET,
    M_NORMAL,
    M_BRANCH,
    M_LOAD_USE,
    M_MEM_STALL,
    M_ABORT
  } mode_t;

  state_t      state;
  state_t      state_nxt;
  mode_t       mode;
  mode_t       run_mode;
  logic        load_use;
  logic        mem_busy;
  logic [4:0]  we_vec;
  logic [3:0]  flush_vec;
  logic [15:0] stall_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign load_use = bus.idex_memR & (bus.idex_rt != 5'd0) &
                    ((bus.idex_rt == bus.ifid_rs) | (bus.idex_rt == bus.ifid_rt));

  // Branch redirect dominates a load-use match: the dependent instruction is squashed anyway.
  assign run_mode = bus.exmem_pcSel ? M_BRANCH :
                    load_use        ? M_LOAD_USE : M_NORMAL;

`ifdef PIPE_CTRL_MEM_WAIT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       timeout_q;

  assign mem_busy = (bus.exmem_memR | bus.exmem_memW) & ~bus.mem_ready;
`else
  logic unused_mem;

  assign mem_busy   = 1'b0;
  assign unused_mem = bus.mem_ready ^ bus.exmem_memR ^ bus.exmem_memW;
`endif

  always_comb begin
    mode      = M_NORMAL;
    state_nxt = RUN;
    if (!rst) begin
      mode = M_RESET;
    end else begin
      case (state)
`ifdef PIPE_CTRL_MEM_WAIT_EN
        MEMWAIT: begin
          if (bus.mem_ready) begin
            mode = run_mode;
          end else if (wait_cnt == WAIT_LAST) begin
            mode = M_ABORT;
          end else begin
            mode      = M_MEM_STALL;
            state_nxt = MEMWAIT;
          end
        end
`endif
        default: begin
          if (mem_busy) begin
            mode      = M_MEM_STALL;
            state_nxt = MEMWAIT;
          end else begin
            mode = run_mode;
          end
        end
      endcase
    end
  end

  // we_vec = {pc, ifid, idex, exmem, memwb}; flush_vec = {ifid, idex, exmem, memwb}
  always_comb begin
    we_vec    = 5'b11111;
    flush_vec = 4'b0000;
    case (mode)
      M_RESET: begin
        we_vec    = 5'b00000;
        flush_vec = 4'b1111;
      end
      M_BRANCH:    flush_vec = 4'b1110;
      M_LOAD_USE: begin
        we_vec    = 5'b00111;
        flush_vec = 4'b0100;
      end
      M_MEM_STALL: begin
        we_vec    = 5'b00000;
        flush_vec = 4'b0001;
      end
      M_ABORT:     flush_vec = 4'b0010;
      default: begin
        we_vec    = 5'b11111;
        flush_vec = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (we_vec != 5'b11111) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
    end
  end

`ifdef PIPE_CTRL_MEM_WAIT_EN
  // Counter restarts from 0 on every RUN->MEMWAIT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nxt == MEMWAIT) begin
        wait_cnt <= (state == MEMWAIT) ? wait_cnt + 8'd1 : 8'd0;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (mode == M_ABORT) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.pc_we       = we_vec[4];
  assign bus.ifid_we     = we_vec[3];
  assign bus.idex_we     = we_vec[2];
  assign bus.exmem_we    = we_vec[1];
  assign bus.memwb_we    = we_vec[0];
  assign bus.ifid_flush  = flush_vec[3];
  assign bus.idex_flush  = flush_vec[2];
  assign bus.exmem_flush = flush_vec[1];
  assign bus.memwb_flush = flush_vec[0];
  assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios then randomized traffic,
// all checked against a cycle-level behavioural model of the controller rules.
module tb_pipe_ctrl;

  localparam int TMO = 4;
`ifdef PIPE_CTRL_MEM_WAIT_EN
  localparam bit MEMEN = 1'b1;
`else
  localparam bit MEMEN = 1'b0;
`endif

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit      m_wait;
  int      m_cnt;
  bit      m_to;
  int      m_stalls;
  // Model outputs for the current cycle
  logic [4:0] exp_we;
  logic [3:0] exp_fl;
  bit      nxt_wait;
  int      nxt_cnt;
  bit      set_to;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
      end
  endtask

  task automatic model_reset();
    m_wait   = 1'b0;
    m_cnt    = 0;
    m_to     = 1'b0;
    m_stalls = 0;
  endtask

  task automatic model_eval();
    bit lu;
    bit busy;
    bit waiting_low;
    lu = bus.idex_memR && (bus.idex_rt != 0) &&
         ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
    busy = MEMEN && (bus.exmem_memR || bus.exmem_memW) && !bus.mem_ready;
    waiting_low = m_wait && !bus.mem_ready;
    nxt_wait = 1'b0;
    nxt_cnt  = 0;
    set_to   = 1'b0;
    if (!rst) begin
      model_reset();
      exp_we = 5'b00000;
      exp_fl = 4'b1111;
    end else if (waiting_low && m_cnt == TMO - 1) begin
      exp_we = 5'b11111;
      exp_fl = 4'b0010;
      set_to = 1'b1;
    end else if (waiting_low || (!m_wait && busy)) begin
      exp_we   = 5'b00000;
      exp_fl   = 4'b0001;
      nxt_wait = 1'b1;
      nxt_cnt  = m_wait ? m_cnt + 1 : 0;
    end else if (bus.exmem_pcSel) begin
      exp_we = 5'b11111;
      exp_fl = 4'b1110;
    end else if (lu) begin
      exp_we = 5'b00111;
      exp_fl = 4'b0100;
    end else begin
      exp_we = 5'b11111;
      exp_fl = 4'b0000;
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else begin
      if (exp_we != 5'b11111 && m_stalls < 65535) m_stalls++;
      m_wait = nxt_wait;
      m_cnt  = nxt_cnt;
      if (set_to) m_to = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    check("we", {11'd0, bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we},
          {11'd0, exp_we});
    check("flush", {12'd0, bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush},
          {12'd0, exp_fl});
    check("stall_cnt", bus.stall_cnt, 16'(m_stalls));
    check("timeout", {15'd0, bus.timeout}, {15'd0, m_to});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic lr,
                        input logic [4:0] xrt, input logic pcs, input logic mr,
                        input logic mw, input logic rdy);
    bus.ifid_rs     = rs;
    bus.ifid_rt     = rt;
    bus.idex_memR   = lr;
    bus.idex_rt     = xrt;
    bus.exmem_pcSel = pcs;
    bus.exmem_memR  = mr;
    bus.exmem_memW  = mw;
    bus.mem_ready   = rdy;
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;

    // Reset state
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // Load-use on rs: one bubble, stall_cnt 0 -> 1
    set_in(5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    set_in(5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    // Load-use on rt
    set_in(5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    // Load to r0 never stalls
    set_in(5'd0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    // Branch taken concurrent with load-use match
    set_in(5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();

    // Load in MEM, memory not ready for 3 cycles then ready
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();
    bus.mem_ready = 1'b1;
    cycle();
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();

    // Store with memory stuck: abort on the TMO-th wait cycle, sticky flag
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (TMO + 1) cycle();
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle();

    // Reset pulsed in the middle of a memory wait
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    cycle();

    // Randomized traffic with small register range so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum MEMWAIT cycles before abort (legal range 2..255).
REQ-002 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ifid_rs, ifid_rt  in  5  source registers of the instruction in ID.
REQ-005 SHALL have ports idex_memR  in  1 and idex_rt  in  5: the instruction in EX is a load, and its destination.
REQ-006 SHALL have ports exmem_pcSel, exmem_memR, exmem_memW  in  1: branch taken / load / store in MEM.
REQ-007 SHALL have port mem_ready  in  1  data memory completes the access this cycle.
REQ-008 SHALL have ports pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1  stage write enables.
REQ-009 SHALL have ports ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  synchronous bubble insert, active-high.
REQ-010 SHALL have ports timeout  out  1 (sticky abort flag) and stall_cnt  out  16 (stall-cycle counter).

Function
REQ-011 SHALL implement FSM with states RUN and MEMWAIT; outputs are combinational in state and current inputs; state and counters are registered.
REQ-012 SHALL define load_use = idex_memR & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
REQ-013 SHALL define mem_busy = (exmem_memR | exmem_memW) & ~mem_ready.
REQ-014 SHALL apply the RUN priority mem_busy > exmem_pcSel > load_use > normal.
REQ-015 SHALL in normal operation drive all *_we=1 and all *_flush=0.
REQ-016 SHALL on exmem_pcSel in RUN drive all *_we=1 and ifid_flush=idex_flush=exmem_flush=1 for that cycle only; load_use is ignored in that cycle.
REQ-017 SHALL on load_use in RUN drive pc_we=0, ifid_we=0, idex_flush=1, with other enables 1; this is exactly one bubble per hazard.
REQ-018 SHALL on mem_busy in RUN drive all *_we=0 and memwb_flush=1, and enter MEMWAIT at the next edge with the wait counter cleared to 0.
REQ-019 SHALL in MEMWAIT with mem_ready=0 drive all *_we=0 and memwb_flush=1, and increment the wait counter.
REQ-020 SHALL in MEMWAIT with mem_ready=1 drive outputs as RUN (load_use evaluated) and return to RUN at the next edge.
REQ-021 SHALL in MEMWAIT with mem_ready=0 and wait counter == TIMEOUT-1 drive all *_we=1 and exmem_flush=1, set timeout=1, and return to RUN.
REQ-022 SHALL keep timeout at 1 until reset.
REQ-023 SHALL increment stall_cnt on every edge where any *_we was 0, saturating at 16'hFFFF with no wrap.

Reset
REQ-024 SHALL while rst=0 force state RUN, wait counter 0, timeout=0, stall_cnt=0.
REQ-025 SHALL while rst=0 force all *_we=0 and all *_flush=1, independent of clk.
REQ-026 SHALL on assertion of rst mid-MEMWAIT abandon the wait immediately, with no timeout set.

Configuration
REQ-027 SHALL gate memory-wait support with macro PIPE_CTRL_MEM_WAIT_EN.
REQ-028 SHALL with PIPE_CTRL_MEM_WAIT_EN defined implement REQ-013 and REQ-018..REQ-022.
REQ-029 SHALL without PIPE_CTRL_MEM_WAIT_EN treat mem_busy as 0, ignore mem_ready, make MEMWAIT unreachable, tie timeout to 0, and omit the wait counter.

Verification
REQ-030 SHALL cover: idex_memR=1, idex_rt=5, ifid_rs=5 -> one cycle of pc_we=0, ifid_we=0, idex_flush=1; stall_cnt goes 0->1.
REQ-031 SHALL cover: idex_memR=1, idex_rt=0, ifid_rs=0 -> no stall, all we=1.
REQ-032 SHALL cover: exmem_pcSel=1 concurrent with a load_use match -> ifid/idex/exmem_flush=1, pc_we=1, no stall.
REQ-033 SHALL cover: exmem_memR=1 with mem_ready held low 3 cycles, then high -> we=0 for 3 cycles, RUN on the 4th edge, stall_cnt=3.
REQ-034 SHALL cover: TIMEOUT=4 with mem_ready stuck 0 -> abort on the 4th MEMWAIT cycle, exmem_flush=1, timeout=1 sticky.
REQ-035 SHALL cover: rst pulsed low during MEMWAIT -> state RUN, timeout=0, stall_cnt=0, all flush=1 while low.
